// File: rtl/piso_pkg.sv
// Shared types and constants for the 4:1 mux front-end serializer.
// SER_MSB_FIRST_EN flips the select order to 3,2,1,0.
package piso_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAPW  = 2'd2
   } state_e;

   localparam int GAP_W = 4;

`ifdef SER_MSB_FIRST_EN
   localparam logic [1:0] SEL_FIRST = 2'd3;
   localparam logic [1:0] SEL_LAST  = 2'd0;
   localparam logic [1:0] SEL_STEP  = 2'd3;
`else
   localparam logic [1:0] SEL_FIRST = 2'd0;
   localparam logic [1:0] SEL_LAST  = 2'd3;
   localparam logic [1:0] SEL_STEP  = 2'd1;
`endif

endpackage

// File: rtl/sel_stepper.sv
// 2-bit loadable select counter; SEL_STEP of 3 acts as a decrement.
// Order (up/down) comes from piso_pkg, set by SER_MSB_FIRST_EN.
module sel_stepper
   import piso_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       en_i,
   output logic [1:0] sel_o,
   output logic       tc_o
);

   logic [1:0] sel_q;
   logic [1:0] sel_d;

   always_comb begin
      sel_d = sel_q;
      if (load_i) begin
         sel_d = SEL_FIRST;
      end else if (en_i) begin
         sel_d = sel_q + SEL_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q <= '0;
      end else begin
         sel_q <= sel_d;
      end
   end

   assign sel_o = sel_q;
   assign tc_o  = (sel_q == SEL_LAST);

endmodule

// File: rtl/piso4_serializer.sv
// 4-bit parallel-in/serial-out driver for a 4:1 mux (s/I/f).
// Build option SER_MSB_FIRST_EN selects MSB-first bit order.
module piso4_serializer
   import piso_pkg::*;
#(
   parameter int GAP = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   output logic [1:0] s,
   output logic [3:0] I,
   output logic       f,
   output logic       f_valid,
   output logic       last
);

   localparam bit HAS_GAP = (GAP > 0);
   localparam logic [GAP_W-1:0] GAP_LD =
      GAP_W'(HAS_GAP ? GAP - 1 : 0);

   state_e           state_q;
   state_e           state_d;
   logic [3:0]       data_q;
   logic [3:0]       data_d;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_d;

   logic       accept;
   logic       step_en;
   logic       tc;
   logic [1:0] sel;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      data_d  = data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (tc) begin
               if (accept) begin
                  state_d = ST_SHIFT;
               end else if (HAS_GAP) begin
                  state_d = ST_GAPW;
                  gap_d   = GAP_LD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAPW: begin
            if (gap_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) data_d = in_data;
   end

   // Ready is gated by rst so nothing is captured during reset.
   always_comb begin
      in_ready = 1'b0;
      f_valid  = 1'b0;
      step_en  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = !rst;
         end
         ST_SHIFT: begin
            f_valid  = 1'b1;
            step_en  = !tc;
            in_ready = tc && !HAS_GAP && !rst;
         end
         ST_GAPW: begin
            in_ready = 1'b0;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   sel_stepper u_sel (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .en_i   (step_en),
      .sel_o  (sel),
      .tc_o   (tc)
   );

   assign s    = sel;
   assign I    = data_q;
   assign f    = data_q[sel];
   assign last = f_valid && tc;

endmodule
